// File: rtl/deser400_pkg.sv
// Shared definitions for the deser400 channel: phase-filter reset value, default widths
// and the slip classification used when the 4-bit sampling phase wraps.
package deser400_pkg;

    localparam logic [3:0] PH_RESET     = 4'b1000;
    localparam int         WORD_DEF     = 5;
    localparam int         SLIP_GAP_DEF = 16;

    typedef enum logic [1:0] {
        SLIP_NONE,
        SLIP_UP,
        SLIP_DOWN
    } slip_t;

    // Only a direct hop between the outermost quadrants is a wrap; larger jumps are ignored.
    function automatic slip_t slip_classify(input logic [1:0] quad_prev, input logic [1:0] quad_cur);
        if (quad_prev == 2'b11 && quad_cur == 2'b00)
            return SLIP_UP;
        if (quad_prev == 2'b00 && quad_cur == 2'b11)
            return SLIP_DOWN;
        return SLIP_NONE;
    endfunction

endpackage

// File: rtl/deser400_bit_packer.sv
// Accumulates 0, 1 or 2 recovered bits per cycle into WORD-bit symbols (first bit in MSB),
// with an optional one-bit discard to move the symbol boundary.
module deser400_bit_packer
    import deser400_pkg::*;
#(
    parameter int WORD = WORD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ena,
    input  logic [1:0]      in_bits,
    input  logic [1:0]      in_cnt,
    input  logic            align,
    output logic [WORD-1:0] dout,
    output logic            dout_valid
);

    localparam int CNT_W = $clog2(WORD + 2);

    logic [WORD:0]      acc;
    logic [CNT_W-1:0]   cnt;
    logic               pend;

    logic               drop;
    logic [1:0]         keep_n;
    logic [WORD:0]      acc_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               full;

    // in_bits[1] is the earlier bit when two arrive; a single bit always sits in in_bits[0],
    // so dropping the first of two leaves exactly the single-bit case.
    always_comb begin
        drop   = (pend | align) && (in_cnt != 2'd0);
        keep_n = in_cnt - {1'b0, drop};
        acc_nx = acc;
        case (keep_n)
            2'd1:    acc_nx = {acc[WORD-1:0], in_bits[0]};
            2'd2:    acc_nx = {acc[WORD-2:0], in_bits};
            default: acc_nx = acc;
        endcase
        cnt_nx = cnt + CNT_W'(keep_n);
        full   = (cnt_nx >= CNT_W'(WORD));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (!ena) begin
            dout_valid <= 1'b0;
        end else begin
            acc        <= acc_nx;
            pend       <= (pend | align) && (in_cnt == 2'd0);
            dout_valid <= full;
            if (full) begin
                dout <= (cnt_nx == CNT_W'(WORD + 1)) ? acc_nx[WORD:1] : acc_nx[WORD-1:0];
                cnt  <= cnt_nx - CNT_W'(WORD);
            end else begin
                cnt  <= cnt_nx;
            end
        end
    end

endmodule

// File: rtl/deser400_phase_selector.sv
// Recovers the serial bit stream from 8x-oversampled periods using the filtered 4-bit phase,
// slipping one bit on phase wrap, and packs the bits into WORD-bit symbols.
module deser400_phase_selector
    import deser400_pkg::*;
#(
    parameter int WORD     = WORD_DEF,
    parameter int SLIP_GAP = SLIP_GAP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ena,
    input  logic [7:0]      sample,
    input  logic [3:0]      phase,
    input  logic            word_align,
    output logic [WORD-1:0] dout,
    output logic            dout_valid,
    output logic            slip_up,
    output logic            slip_down,
    output logic            slip_err
);

    localparam int GAP_W = $clog2(SLIP_GAP + 1);

    logic [7:0]       sample_d1, sample_d2;
    logic [3:0]       ph_q, phase_prev;
    logic             vld_p0, vld_p1;
    logic [15:0]      win;
    slip_t            slip_code;
    logic [1:0]       bits_c, nbits_c;
    logic [1:0]       bits_p2, nbits_p2;
    logic [GAP_W-1:0] gap_cnt;

    // Stage 1: window registers; vld_p1 marks both window halves as holding real samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_d1  <= '0;
            sample_d2  <= '0;
            ph_q       <= PH_RESET;
            phase_prev <= PH_RESET;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else if (ena) begin
            sample_d1  <= sample;
            sample_d2  <= sample_d1;
            ph_q       <= phase;
            phase_prev <= ph_q;
            vld_p0     <= 1'b1;
            vld_p1     <= vld_p0;
        end
    end

    assign win = {sample_d1, sample_d2};

    // Stage 2: wrap detect and 16:1 bit select
    always_comb begin
        slip_code = SLIP_NONE;
        bits_c    = 2'b00;
        nbits_c   = 2'd0;
        if (vld_p1) begin
            slip_code = slip_classify(phase_prev[3:2], ph_q[3:2]);
            case (slip_code)
                SLIP_UP:   nbits_c = 2'd0;
                SLIP_DOWN: begin
                    bits_c  = {win[{1'b0, ph_q[2:0]}], win[ph_q]};
                    nbits_c = 2'd2;
                end
                default: begin
                    bits_c  = {1'b0, win[ph_q]};
                    nbits_c = 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits_p2   <= '0;
            nbits_p2  <= '0;
            slip_up   <= 1'b0;
            slip_down <= 1'b0;
            slip_err  <= 1'b0;
            gap_cnt   <= GAP_W'(SLIP_GAP);
        end else if (!ena) begin
            slip_up   <= 1'b0;
            slip_down <= 1'b0;
        end else begin
            bits_p2   <= bits_c;
            nbits_p2  <= nbits_c;
            slip_up   <= (slip_code == SLIP_UP);
            slip_down <= (slip_code == SLIP_DOWN);
            if (slip_code != SLIP_NONE) begin
                gap_cnt <= '0;
                if (gap_cnt < GAP_W'(SLIP_GAP))
                    slip_err <= 1'b1;
            end else if (gap_cnt < GAP_W'(SLIP_GAP)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    // Stage 3: symbol packing
    deser400_bit_packer #(
        .WORD (WORD)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .in_bits    (bits_p2),
        .in_cnt     (nbits_p2),
        .align      (word_align),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_deser400_phase_selector.sv
// Scoreboard bench for deser400_phase_selector: directed line patterns, expected symbols queued
// up front and checked by an independent monitor whenever dout_valid is seen.
module tb_deser400_phase_selector;

    localparam int WORD = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ena = 1'b0;
    logic [7:0]      sample = '0;
    logic [3:0]      phase = '0;
    logic            word_align = 1'b0;
    logic [WORD-1:0] dout;
    logic            dout_valid, slip_up, slip_down, slip_err;

    deser400_phase_selector #(
        .WORD     (WORD),
        .SLIP_GAP (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .sample     (sample),
        .phase      (phase),
        .word_align (word_align),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slip_up    (slip_up),
        .slip_down  (slip_down),
        .slip_err   (slip_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD-1:0] d;
        int              cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    int          up_cnt = 0, dn_cnt = 0, up_cyc = 0, dn_cyc = 0;
    logic [0:63] lb;

    // Posedges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [WORD-1:0] d, input int c);
        q.push_back('{d: d, cyc: c});
    endtask

    // Monitor: pops the scoreboard on every strobe, independent of stimulus.
    always @(negedge clk) begin
        if (!reset) begin
            if (slip_up) begin
                up_cnt++;
                up_cyc = cyc;
            end
            if (slip_down) begin
                dn_cnt++;
                dn_cyc = cyc;
            end
            if (dout_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("dout", int'(dout), int'(e.d));
                    if (e.cyc != 0)
                        check("dout_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [3:0] ph_of(input int tid, input int j);
        case (tid)
            2:       return (j <= 6) ? 4'd7 : (j <= 10) ? 4'd8 : 4'd9;
            3:       return (j <= 8) ? 4'd14 : 4'd1;
            4:       return (j <= 10) ? 4'd1 : 4'd13;
            6:       return (j <= 4) ? 4'd14 : (j <= 9) ? 4'd1 : 4'd13;
            default: return 4'd4;
        endcase
    endfunction

    // Assert reset for two cycles and leave it asserted at a negedge.
    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        ena = 1'b0;
        sample = '0;
        phase = '0;
        word_align = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        up_cnt = 0;
        dn_cnt = 0;
        up_cyc = 0;
        dn_cyc = 0;
    endtask

    // Line bit L[j] occupies the upper half of period j and the lower half of period j+1.
    task automatic run_test(input int tid, input int nvec, input logic [0:63] lbv);
        for (int j = 1; j <= nvec; j++) begin
            if (j > 1) @(negedge clk);
            reset = 1'b0;
            ena = 1'b1;
            sample = {{4{lbv[j]}}, {4{lbv[j-1]}}};
            phase = ph_of(tid, j);
            word_align = (tid == 5 && j == 9);
        end
        @(negedge clk);
        ena = 1'b0;
        word_align = 1'b0;
    endtask

    task automatic finish_test(input string name, input int n_up, input int c_up,
                               input int n_dn, input int c_dn, input int err);
        repeat (3) @(negedge clk);
        check({name, "_pending"}, q.size(), 0);
        check({name, "_slip_up_count"}, up_cnt, n_up);
        check({name, "_slip_up_cycle"}, up_cyc, c_up);
        check({name, "_slip_down_count"}, dn_cnt, n_dn);
        check({name, "_slip_down_cycle"}, dn_cyc, c_dn);
        check({name, "_slip_err"}, int'(slip_err), err);
    endtask

    initial begin
        // Reset state
        start();
        check("reset_dout", int'(dout), 0);
        check("reset_dout_valid", int'(dout_valid), 0);
        check("reset_slip_up", int'(slip_up), 0);
        check("reset_slip_down", int'(slip_down), 0);
        check("reset_slip_err", int'(slip_err), 0);

        // 1: alternating F0/0F at phase 4
        lb = 64'h5555_5555_5555_5555;
        push(5'b10101, 8);
        push(5'b01010, 13);
        push(5'b10101, 18);
        push(5'b01010, 23);
        run_test(1, 24, lb);
        finish_test("alt", 0, 0, 0, 0, 0);

        // 2: phase 7 -> 8 -> 9, stream stays continuous
        start();
        lb = '0;
        lb[0:20] = {1'b0, 5'b11001, 5'b01110, 5'b00110, 5'b10011};
        push(5'b11001, 8);
        push(5'b01110, 13);
        push(5'b00110, 18);
        push(5'b10011, 23);
        run_test(2, 24, lb);
        finish_test("ph78", 0, 0, 0, 0, 0);

        // 3: phase 14 -> 1, slip up, second symbol one cycle late
        start();
        lb = '0;
        lb[0:21] = {1'b0, 1'b0, 5'b10110, 2'b10, 2'b11, 5'b01001, 5'b11100, 1'b0};
        push(5'b10110, 8);
        push(5'b10011, 14);
        push(5'b01001, 19);
        push(5'b11100, 24);
        run_test(3, 25, lb);
        finish_test("slipup", 1, 10, 0, 0, 0);

        // 4: phase 1 -> 13, slip down with a carried remainder bit
        start();
        lb = '0;
        lb[0:21] = {5'b11010, 4'b0111, 1'b1, 1'b0, 5'b10011, 5'b00101, 1'b1};
        push(5'b11010, 8);
        push(5'b01110, 13);
        push(5'b10011, 17);
        push(5'b00101, 22);
        run_test(4, 22, lb);
        finish_test("slipdn", 0, 0, 1, 12, 0);

        // 5: word_align on an incrementing symbol stream
        start();
        lb = '0;
        lb[0:30] = {1'b0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        push(5'b00001, 8);
        push(5'b00100, 14);
        push(5'b00110, 19);
        push(5'b01000, 24);
        push(5'b01010, 29);
        run_test(5, 29, lb);
        finish_test("align", 0, 0, 0, 0, 0);

        // 6: two slips five cycles apart, then asynchronous reset mid-symbol
        start();
        lb = '1;
        push(5'b11111, 9);
        push(5'b11111, 13);
        run_test(6, 16, lb);
        finish_test("sliperr", 1, 6, 1, 11, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dout", int'(dout), 0);
        check("async_reset_dout_valid", int'(dout_valid), 0);
        check("async_reset_slip_err", int'(slip_err), 0);
        @(negedge clk);
        q.delete();
        up_cnt = 0;
        dn_cnt = 0;
        up_cyc = 0;
        dn_cyc = 0;
        lb = '0;
        lb[0:10] = {1'b0, 5'b10011, 5'b01101};
        push(5'b10011, 8);
        push(5'b01101, 13);
        run_test(7, 16, lb);
        finish_test("post_reset", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
